mux: RTL and testbench
======================

MUX -- requirements
Module: mux

Interface
REQ-001 Parameter SIZE_CTRL, default 2: width of the select bus; the number of input channels SHALL be 2**SIZE_CTRL.
REQ-002 Parameter WIRE, default 1: width of each data channel and of each output.
REQ-003 Port clk, input, 1, the single clock; all sequential logic SHALL be rising-edge triggered.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port ctrl, input, SIZE_CTRL, channel select as an unsigned binary index.
REQ-006 Port in, input, (2**SIZE_CTRL)*WIRE, packed channels; channel k SHALL occupy bits [k*WIRE +: WIRE].
REQ-007 Port out, output, WIRE, combinational selected channel.
REQ-008 Port out_q, output, WIRE, registered copy of out.

Function
REQ-009 out SHALL equal channel ctrl of in at all times, with zero cycle latency, purely combinational, and SHALL not depend on clk or rst.
REQ-010 out SHALL follow any change on ctrl or on the selected channel within the same delta/settle time; unselected channels SHALL have no effect on out.
REQ-011 Every ctrl value 0..2**SIZE_CTRL-1 SHALL be legal; no out-of-range case exists, since the channel count is an exact power of two.
REQ-012 out_q SHALL load out on every rising clk edge while rst is low, for a latency of exactly 1 cycle from ctrl/in to out_q.
REQ-013 X/Z on a ctrl bit SHALL propagate as X on out; this behaviour is not required to be masked.
REQ-014 SIZE_CTRL = 1 (2 channels) and WIRE > 1 SHALL be supported without code change; SIZE_CTRL >= 1 SHALL be enforced by an elaboration-time check.

Reset
REQ-015 While rst is high, out_q SHALL be all zeros, asserted immediately without waiting for a clock edge.
REQ-016 Deassertion of rst SHALL take effect at the next rising clk edge, when out_q loads the current out.
REQ-017 rst SHALL NOT affect out; the combinational path remains live during reset.
REQ-018 rst asserted mid-operation SHALL clear out_q within the same time step; no other state exists.

Structure
REQ-019 The selection SHALL be built as a recursive binary tree of the sub-module mux2 (2:1 mux, WIRE wide, select 1 bit).
REQ-020 At tree level L, channels SHALL be paired by ctrl[L], with ctrl[0] at the leaf level and ctrl[SIZE_CTRL-1] at the root.
REQ-021 mux SHALL instantiate the tree through a generate loop, using 2**SIZE_CTRL-1 mux2 instances in total.
REQ-022 No shared package is required; parameters are module-local, and any channel-width helper functions belong in the routing package if one exists.
REQ-023 The out_q register SHALL be the only sequential element in the block.

Verification
REQ-024 SIZE_CTRL=2, WIRE=1, in=4'b0101, with ctrl stepped 0,1,2,3 every 5 time units, SHALL give out=1,0,1,0.
REQ-025 The same stimulus with clk running SHALL give out_q matching out one rising edge later; with rst held high, out_q SHALL be 0 throughout.
REQ-026 With ctrl=2 fixed, toggling in[2] SHALL make out follow, and toggling in[0], in[1] and in[3] SHALL leave out unchanged.
REQ-027 SIZE_CTRL=3, WIRE=4, channel k=k+8 (values 8..15), with ctrl swept 0..7, SHALL give out=8..15 and out_q one cycle behind.
REQ-028 With out_q=1, asserting rst between clock edges SHALL make out_q 0 immediately; after release, the first rising edge SHALL restore out_q=out.
REQ-029 A random sweep of 1000 vectors, comparing out against the reference model in[ctrl*WIRE +: WIRE], SHALL show zero mismatches.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared helpers for the mux selection tree: channel count and the
// flat node-array layout used to wire the binary tree level by level.
package mux_pkg;

  // Number of input channels for a given select width.
  function automatic int unsigned chan_count(input int unsigned size_ctrl);
    return 32'd1 << size_ctrl;
  endfunction

  // Index of the first node of tree level 'level' in the flat node array.
  // Level 0 holds the leaves (the input channels). Each following level
  // holds half as many nodes as the one below it. The root is the last
  // node, at index 2*N-2.
  function automatic int unsigned level_base(input int unsigned size_ctrl,
                                             input int unsigned level);
    int unsigned two_n;
    two_n = 2 * chan_count(size_ctrl);
    return two_n - (two_n >> level);
  endfunction

endpackage

// File: rtl/mux2.sv
// 2:1 multiplexer, WIRE bits wide; the building block of the mux tree.
module mux2 #(
  parameter int WIRE = 1
) (
  input  logic [WIRE-1:0] a,
  input  logic [WIRE-1:0] b,
  input  logic            sel,
  output logic [WIRE-1:0] y
);

  // Pass b when sel is high, otherwise a. An unknown sel yields X on y.
  always_comb begin
    y = sel ? b : a;
  end

endmodule

// File: rtl/mux.sv
// Parameterised 2**SIZE_CTRL : 1 multiplexer built as a binary tree of mux2.
// out is purely combinational. out_q is out registered once.
module mux
  import mux_pkg::*;
#(
  parameter int SIZE_CTRL = 2,
  parameter int WIRE      = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [SIZE_CTRL-1:0]             ctrl,
  input  logic [(2**SIZE_CTRL)*WIRE-1:0]   in,
  output logic [WIRE-1:0]                  out,
  output logic [WIRE-1:0]                  out_q
);

  localparam int unsigned NCH   = chan_count(SIZE_CTRL);
  localparam int unsigned NNODE = 2 * NCH - 1;

  // Flat node array: the leaves come first, then each tree level in turn.
  // The root is the last node.
  logic [WIRE-1:0] node [NNODE];

  if (SIZE_CTRL < 1) begin : g_size_check
    $error("mux: SIZE_CTRL must be at least 1");
  end

  for (genvar k = 0; k < NCH; k++) begin : g_leaf
    assign node[k] = in[k*WIRE +: WIRE];
  end

  // Level l pairs adjacent nodes using ctrl[l]. The leaves use ctrl[0] and
  // the root uses ctrl[SIZE_CTRL-1].
  for (genvar l = 0; l < SIZE_CTRL; l++) begin : g_level
    for (genvar j = 0; j < (NCH >> (l + 1)); j++) begin : g_node
      mux2 #(
        .WIRE (WIRE)
      ) u_mux2 (
        .a   (node[level_base(SIZE_CTRL, l) + 2*j]),
        .b   (node[level_base(SIZE_CTRL, l) + 2*j + 1]),
        .sel (ctrl[l]),
        .y   (node[level_base(SIZE_CTRL, l + 1) + j])
      );
    end
  end

  assign out = node[NNODE-1];

  // Register the selected channel. Reset clears it immediately, with no
  // clock edge needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_mux.sv
// Directed and random checks of mux in three parameterisations:
// 4x1 bit, 8x4 bit and 2x8 bit.
module tb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance a: SIZE_CTRL=2, WIRE=1
  logic [1:0]  ctrl_a;
  logic [3:0]  in_a;
  logic        out_a, outq_a;

  // Instance b: SIZE_CTRL=3, WIRE=4
  logic [2:0]  ctrl_b;
  logic [31:0] in_b;
  logic [3:0]  out_b, outq_b;

  // Instance c: SIZE_CTRL=1, WIRE=8
  logic        ctrl_c;
  logic [15:0] in_c;
  logic [7:0]  out_c, outq_c;

  mux #(.SIZE_CTRL(2), .WIRE(1)) dut_a (
    .clk(clk), .rst(rst), .ctrl(ctrl_a), .in(in_a), .out(out_a), .out_q(outq_a)
  );
  mux #(.SIZE_CTRL(3), .WIRE(4)) dut_b (
    .clk(clk), .rst(rst), .ctrl(ctrl_b), .in(in_b), .out(out_b), .out_q(outq_b)
  );
  mux #(.SIZE_CTRL(1), .WIRE(8)) dut_c (
    .clk(clk), .rst(rst), .ctrl(ctrl_c), .in(in_c), .out(out_c), .out_q(outq_c)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel values of in_a = 4'b0101, indexed by ctrl
  logic exp_a [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    logic [3:0] ref_b;
    logic       ref_a;
    logic       prev;

    rst    = 1'b1;
    ctrl_a = 2'd0;
    in_a   = 4'b0101;
    ctrl_b = 3'd0;
    for (int k = 0; k < 8; k++) in_b[k*4 +: 4] = 4'(k + 8);
    ctrl_c = 1'b0;
    in_c   = 16'hA55A;

    // Reset state, before any clock edge
    #1;
    check("rst_outq_a", 8'(outq_a), 8'h00);
    check("rst_outq_b", 8'(outq_b), 8'h00);
    check("rst_outq_c", outq_c, 8'h00);
    check("rst_out_live_a", 8'(out_a), 8'h01);

    // ctrl stepped every 5 time units while reset is held
    for (int i = 0; i < 4; i++) begin
      ctrl_a = 2'(i);
      #1;
      check($sformatf("rstsweep_out_%0d", i), 8'(out_a), 8'(exp_a[i]));
      check($sformatf("rstsweep_outq_%0d", i), 8'(outq_a), 8'h00);
      #4;
    end

    // Release reset. out_q loads at the next rising edge.
    @(negedge clk);
    rst = 1'b0;
    ctrl_a = 2'd0;
    #1;
    check("release_hold", 8'(outq_a), 8'h00);
    @(posedge clk); #1;
    check("release_load", 8'(outq_a), 8'h01);

    // out follows immediately. out_q follows one edge later.
    prev = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ctrl_a = 2'(i);
      #1;
      check($sformatf("sweep_out_%0d", i), 8'(out_a), 8'(exp_a[i]));
      check($sformatf("sweep_outq_old_%0d", i), 8'(outq_a), 8'(prev));
      @(posedge clk); #1;
      check($sformatf("sweep_outq_%0d", i), 8'(outq_a), 8'(exp_a[i]));
      prev = exp_a[i];
    end

    // Only the selected channel affects out
    @(negedge clk);
    ctrl_a = 2'd2;
    in_a   = 4'b0101;
    #1; check("sel2_base", 8'(out_a), 8'h01);
    in_a[2] = 1'b0;
    #1; check("sel2_tog_lo", 8'(out_a), 8'h00);
    in_a[2] = 1'b1;
    #1; check("sel2_tog_hi", 8'(out_a), 8'h01);
    in_a[0] = ~in_a[0]; #1; check("unsel0_hi", 8'(out_a), 8'h01);
    in_a[1] = ~in_a[1]; #1; check("unsel1_hi", 8'(out_a), 8'h01);
    in_a[3] = ~in_a[3]; #1; check("unsel3_hi", 8'(out_a), 8'h01);
    in_a[2] = 1'b0;     #1; check("sel2_lo", 8'(out_a), 8'h00);
    in_a[0] = ~in_a[0]; #1; check("unsel0_lo", 8'(out_a), 8'h00);
    in_a[3] = ~in_a[3]; #1; check("unsel3_lo", 8'(out_a), 8'h00);

    // Reset asserted between clock edges clears out_q at once
    @(negedge clk);
    in_a   = 4'b0101;
    ctrl_a = 2'd0;
    @(posedge clk); #1;
    check("midrst_pre", 8'(outq_a), 8'h01);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_outq_a", 8'(outq_a), 8'h00);
    check("midrst_outq_b", 8'(outq_b), 8'h00);
    check("midrst_out_live", 8'(out_a), 8'h01);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_rel_hold", 8'(outq_a), 8'h00);
    @(posedge clk); #1;
    check("midrst_rel_load", 8'(outq_a), 8'h01);

    // 8 channels of 4 bits: channel k holds k+8
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ctrl_b = 3'(k);
      #1;
      check($sformatf("b_out_%0d", k), 8'(out_b), 8'(k + 8));
      if (k > 0) check($sformatf("b_outq_old_%0d", k), 8'(outq_b), 8'(k + 7));
      @(posedge clk); #1;
      check($sformatf("b_outq_%0d", k), 8'(outq_b), 8'(k + 8));
    end

    // Two channels, 8 bits wide
    @(negedge clk);
    ctrl_c = 1'b0;
    #1; check("c_out_0", out_c, 8'h5A);
    ctrl_c = 1'b1;
    #1; check("c_out_1", out_c, 8'hA5);
    @(posedge clk); #1;
    check("c_outq_1", outq_c, 8'hA5);

    // Random sweep against a reference shift model
    for (int n = 0; n < 1000; n++) begin
      in_a   = 4'($urandom);
      ctrl_a = 2'($urandom_range(0, 3));
      in_b   = $urandom;
      ctrl_b = 3'($urandom_range(0, 7));
      #1;
      ref_a = in_a[ctrl_a];
      ref_b = 4'((in_b >> (32'(ctrl_b) * 4)) & 32'hF);
      check($sformatf("rand_a_%0d", n), 8'(out_a), 8'(ref_a));
      check($sformatf("rand_b_%0d", n), 8'(out_b), 8'(ref_b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
